// File: rtl/mem_resp_types.sv
// Shared types and constants for the memory responder.
package mem_resp_types;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StTurn
  } mem_state_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port, byte-enabled, word-addressed RAM with a one-cycle registered read.
module mem_bank #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [31:0] ram [Depth];

  // Lane-masked write and registered read of the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= ram[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request, answers LATENCY cycles later,
// then inserts one turnaround cycle before accepting the next.
module mem_responder
  import mem_resp_types::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        proto_err
);

  // Out-of-range latencies are clamped into the counter's range.
  localparam int unsigned LatEff = (LATENCY < 1) ? 1 :
                                   (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
  localparam cnt_t CntInit = cnt_t'(LatEff - 1);

  mem_state_t            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  resp_q, resp_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  req;
  logic                  bank_we;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] bank_idx;
  logic [31:0]           bank_rdata;
  logic                  unused_addr;

  assign req         = mem_read | mem_write;
  assign req_idx     = mem_address[DEPTH_LOG2+1:2];
  assign unused_addr = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};

  // In IDLE the bank is pointed at the live address so a LATENCY==1 read lands in RESP.
  assign bank_idx = (state_q == StIdle) ? req_idx : idx_q;
  // Gated by reset so an aborted transaction never commits.
  assign bank_we  = rst & (state_q == StResp) & write_q;

  mem_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .be   (be_q),
    .idx  (bank_idx),
    .wdata(wdata_q),
    .rdata(bank_rdata)
  );

  // Next-state logic for the FSM, latency counter, request latches and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    resp_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          write_d = mem_write;
          idx_d   = req_idx;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          cnt_d   = CntInit;
          if (mem_read && mem_write) err_d = 1'b1;
          if (LatEff == 1) begin
            state_d = StResp;
            resp_d  = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!req) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q <= cnt_t'(1)) begin
          cnt_d   = '0;
          state_d = StResp;
          resp_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StResp: begin
        if (!write_q) rdata_d = bank_rdata;
        state_d = StTurn;
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = ((state_q == StResp) && !write_q) ? bank_rdata : rdata_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one LATENCY=3 instance and one LATENCY=1 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, sel1;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        resp0, resp1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        resp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [int];
  logic [31:0] held0, held1;

  always #5 clk = ~clk;

  assign resp  = sel1 ? resp1 : resp0;
  assign rdata = sel1 ? rdata1 : rdata0;

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read & ~sel1),
    .mem_write      (mem_write & ~sel1),
    .mem_byte_enable(be),
    .mem_address    (addr),
    .mem_wdata      (wdata),
    .mem_resp       (resp0),
    .mem_rdata      (rdata0),
    .proto_err      (err0)
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read & sel1),
    .mem_write      (mem_write & sel1),
    .mem_byte_enable(be),
    .mem_address    (addr),
    .mem_wdata      (wdata),
    .mem_resp       (resp1),
    .mem_rdata      (rdata1),
    .proto_err      (err1)
  );

  function automatic int key(input bit s, input logic [31:0] a);
    return int'(s) * 4096 + int'(a[11:2]);
  endfunction

  function automatic void model_wr(input bit s, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] b);
    logic [31:0] w;
    int k;
    k = key(s, a);
    w = model.exists(k) ? model[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
    model[k] = w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    held0 = 32'h0;
    held1 = 32'h0;
  endtask

  // Drive one request, wait (bounded) for mem_resp, report latency, data and pulse tail.
  task automatic issue(input bit rd_op, input bit wr_op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input int hold_extra,
                       output int lat, output logic [31:0] rv, output bit got,
                       output logic tail);
    @(negedge clk);
    mem_read = rd_op; mem_write = wr_op; addr = a; wdata = wd; be = b;
    got = 1'b0; lat = 0; rv = '0; tail = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (resp) begin
        got = 1'b1; lat = k; rv = rdata;
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      tail = resp;
    end
    repeat (hold_extra) @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (resp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b want 0", resp0); end
    if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b want 0", err0); end
    if (resp1 !== 1'b0) begin errors++; $display("FAIL reset_resp1: got %b want 0", resp1); end
    if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b want 0", err1); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rv, e; bit got; logic tail;
    sel1 = 1'b0;
    issue(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, lat, rv, got, tail);
    model_wr(1'b0, 32'h40, 32'hDEADBEEF, 4'hF);
    checks += 4;
    if (!got) begin errors++; $display("FAIL wr_resp: got none want resp"); end
    if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    if (tail !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: got %b want 0", tail); end
    if (rv !== held0) begin errors++; $display("FAIL wr_rdata_held: got %h want %h", rv, held0); end
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, lat, rv, got, tail);
    checks += 2;
    if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL rd_scoreboard: got empty want entry");
    end else begin
      e = exp_q.pop_front();
      if (rv !== e) begin errors++; $display("FAIL rd_data: got %h want %h", rv, e); end
      held0 = e;
    end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rv, e; bit got; logic tail;
    issue(1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, 0, lat, rv, got, tail);
    model_wr(1'b0, 32'h80, 32'h11223344, 4'hF);
    issue(1'b0, 1'b1, 32'h80, 32'hAABBCCDD, 4'b0101, 0, lat, rv, got, tail);
    model_wr(1'b0, 32'h80, 32'hAABBCCDD, 4'b0101);
    checks += 1;
    if (!got) begin errors++; $display("FAIL be_write_resp: got none want resp"); end
    exp_q.push_back(32'h11BB33DD);
    issue(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 0, lat, rv, got, tail);
    checks += 1;
    e = exp_q.pop_front();
    if (rv !== e) begin errors++; $display("FAIL be_merge: got %h want %h", rv, e); end
    held0 = e;
    // Zero byte-enable write still completes and leaves the word alone.
    issue(1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, 0, lat, rv, got, tail);
    checks += 1;
    if (!got) begin errors++; $display("FAIL be_zero_resp: got none want resp"); end
    exp_q.push_back(model[key(1'b0, 32'h80)]);
    issue(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 0, lat, rv, got, tail);
    checks += 1;
    e = exp_q.pop_front();
    if (rv !== e) begin errors++; $display("FAIL be_zero_data: got %h want %h", rv, e); end
    held0 = e;
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rv, e; bit got; logic tail; bit extra;
    exp_q.push_back(model[key(1'b0, 32'h80)]);
    issue(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1, lat, rv, got, tail);
    e = exp_q.pop_front();
    extra = tail;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (resp) extra = 1'b1;
    end
    checks += 2;
    if (rv !== e) begin errors++; $display("FAIL hold_data: got %h want %h", rv, e); end
    if (extra) begin errors++; $display("FAIL hold_second_resp: got 1 want 0"); end
    held0 = e;
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, lat, rv, got, tail);
    e = exp_q.pop_front();
    checks += 3;
    if (lat != 3) begin errors++; $display("FAIL hold_next_lat: got %0d want 3", lat); end
    if (rv !== e) begin errors++; $display("FAIL hold_next_data: got %h want %h", rv, e); end
    if (err0 !== 1'b0) begin errors++; $display("FAIL hold_err: got %b want 0", err0); end
    held0 = e;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rv, e; bit got; logic tail; bit seen;
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h40;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (resp) seen = 1'b1;
    end
    checks += 2;
    if (seen) begin errors++; $display("FAIL abort_resp: got 1 want 0"); end
    if (err0 !== 1'b1) begin errors++; $display("FAIL abort_err: got %b want 1", err0); end
    exp_q.push_back(32'h11BB33DD);
    issue(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 0, lat, rv, got, tail);
    e = exp_q.pop_front();
    checks += 2;
    if (lat != 3) begin errors++; $display("FAIL abort_next_lat: got %0d want 3", lat); end
    if (rv !== e) begin errors++; $display("FAIL abort_next_data: got %h want %h", rv, e); end
    do_reset();
    checks += 1;
    if (err0 !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b want 0", err0); end
    // Reset during BUSY must drop the pending write.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h40; wdata = 32'h99999999; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(model[key(1'b0, 32'h40)]);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, lat, rv, got, tail);
    e = exp_q.pop_front();
    checks += 1;
    if (rv !== e) begin errors++; $display("FAIL reset_abort_data: got %h want %h", rv, e); end
    held0 = e;
  endtask

  task automatic test_both();
    int lat; logic [31:0] rv, e; bit got; logic tail;
    issue(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 0, lat, rv, got, tail);
    model_wr(1'b0, 32'h10, 32'h12345678, 4'hF);
    checks += 3;
    if (!got) begin errors++; $display("FAIL both_resp: got none want resp"); end
    if (rv !== held0) begin errors++; $display("FAIL both_rdata_held: got %h want %h", rv, held0); end
    if (err0 !== 1'b1) begin errors++; $display("FAIL both_err: got %b want 1", err0); end
    exp_q.push_back(32'h12345678);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rv, got, tail);
    e = exp_q.pop_front();
    checks += 1;
    if (rv !== e) begin errors++; $display("FAIL both_read: got %h want %h", rv, e); end
    held0 = e;
  endtask

  task automatic test_alias(input bit s, input int want_lat);
    int lat; logic [31:0] rv, e; bit got; logic tail;
    sel1 = s;
    issue(1'b0, 1'b1, 32'h00001004, 32'hCAFEF00D, 4'hF, 0, lat, rv, got, tail);
    model_wr(s, 32'h00001004, 32'hCAFEF00D, 4'hF);
    checks += 1;
    if (lat != want_lat) begin errors++; $display("FAIL alias_wr_lat: got %0d want %0d", lat, want_lat); end
    exp_q.push_back(32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'h00000004, 32'h0, 4'h0, 0, lat, rv, got, tail);
    e = exp_q.pop_front();
    checks += 3;
    if (lat != want_lat) begin errors++; $display("FAIL alias_rd_lat: got %0d want %0d", lat, want_lat); end
    if (rv !== e) begin errors++; $display("FAIL alias_data: got %h want %h", rv, e); end
    if (tail !== 1'b0) begin errors++; $display("FAIL alias_pulse_width: got %b want 0", tail); end
    sel1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rv, e, a, wd; bit got; logic tail; logic [3:0] b;
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(i * 4);
      wd = $urandom;
      issue(1'b0, 1'b1, a, wd, 4'hF, 0, lat, rv, got, tail);
      model_wr(1'b0, a, wd, 4'hF);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(i * 4);
      wd = $urandom;
      b = 4'($urandom_range(0, 15));
      issue(1'b0, 1'b1, a, wd, b, 0, lat, rv, got, tail);
      model_wr(1'b0, a, wd, b);
    end
    for (int i = 0; i < 8; i++) begin
      a = 32'h200 + 32'(i * 4);
      exp_q.push_back(model[key(1'b0, a)]);
      issue(1'b1, 1'b0, a, 32'h0, 4'h0, 0, lat, rv, got, tail);
      checks += 2;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_scoreboard: got empty want entry");
      end else begin
        e = exp_q.pop_front();
        if (rv !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rv, e); end
      end
      if (lat != 3) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want 3", i, lat); end
    end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; sel1 = 1'b0;
    be = 4'h0; addr = 32'h0; wdata = 32'h0;
    held0 = 32'h0; held1 = 32'h0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_hold();
    test_abort();
    test_both();
    test_alias(1'b0, 3);
    test_alias(1'b1, 1);
    test_back_to_back();
    checks += 1;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
